// File: rtl/eh2_pkg.sv
// rtl/eh2_pkg.sv - shared EH2 types for the divider packet and divide scheduler FSM
//
// Purpose : common typedefs used by the divide scheduler and its arbiter.
// Contents: eh2_div_pkt_t         - divider issue packet {valid, unsign, rem}
//           eh2_div_sched_state_t - divide scheduler FSM state (IDLE, RUN, WB)
package eh2_pkg;

  typedef struct packed {
    logic valid;
    logic unsign;
    logic rem;
  } eh2_div_pkt_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_WB   = 2'd2
  } eh2_div_sched_state_t;

endpackage

// File: rtl/eh2_exu_div_rr_arb.sv
// rtl/eh2_exu_div_rr_arb.sv - two-thread round-robin grant for the divide scheduler
//
// Purpose : picks one of two requesting threads; when both request, the thread
//           that was not granted last wins. History only moves on an accepted
//           handshake so a grant that is not taken does not cost a thread its turn.
// Ports   : clk    - core clock
//           rst_l  - async active-low reset (history favours thread 0)
//           valid  - per-thread eligible request
//           accept - grant was taken this cycle
//           grant  - one-hot grant (all zero when nothing is valid)
module eh2_exu_div_rr_arb (
  input  logic       clk,
  input  logic       rst_l,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  // Thread granted most recently; reset to 1 so thread 0 wins the first tie.
  logic last_q;

  assign grant[0] = valid[0] & (~valid[1] | last_q);
  assign grant[1] = valid[1] & (~valid[0] | ~last_q);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/eh2_exu_div_sched.sv
// rtl/eh2_exu_div_sched.sv - shares one divider between two threads, one op in flight
//
// Purpose : accepts divide requests from two threads (round-robin), issues them
//           to the divider, handles per-thread flush/cancel and returns the
//           result through a ready/valid writeback port.
// Config  : RV_DIV_RESULT_CACHE_EN - when defined, the last completed operation is
//           remembered and an identical request is answered without the divider.
// Ports   : clk, rst_l                   - clock, async active-low reset
//           req_valid/req_ready          - per-thread request handshake
//           req_rs1/req_rs2              - per-thread dividend / divisor
//           req_unsign/req_rem/req_rd    - per-thread op kind and destination tag
//           flush                        - per-thread pipeline flush
//           div_dp/div_dividend/div_divisor/div_cancel - divider issue side
//           div_finish_dly/div_out       - divider result side
//           wb_valid/wb_ready/wb_tid/wb_rd/wb_data     - writeback port
module eh2_exu_div_sched
  import eh2_pkg::*;
#(
  parameter int NUM_THREADS = 2,
  parameter int TAG_W       = 5
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic [NUM_THREADS-1:0]       req_valid,
  output logic [NUM_THREADS-1:0]       req_ready,
  input  logic [NUM_THREADS*32-1:0]    req_rs1,
  input  logic [NUM_THREADS*32-1:0]    req_rs2,
  input  logic [NUM_THREADS-1:0]       req_unsign,
  input  logic [NUM_THREADS-1:0]       req_rem,
  input  logic [NUM_THREADS*TAG_W-1:0] req_rd,
  input  logic [NUM_THREADS-1:0]       flush,
  output eh2_div_pkt_t                 div_dp,
  output logic [31:0]                  div_dividend,
  output logic [31:0]                  div_divisor,
  output logic                         div_cancel,
  input  logic                         div_finish_dly,
  input  logic [31:0]                  div_out,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic                         wb_tid,
  output logic [TAG_W-1:0]             wb_rd,
  output logic [31:0]                  wb_data
);

  eh2_div_sched_state_t state_q;

  logic             tid_q;
  logic [TAG_W-1:0] rd_q;
  logic [31:0]      data_q;

  logic [1:0]       elig;
  logic [1:0]       grant;
  logic             accept;
  logic             sel;
  logic             own_flush;
  logic             cache_hit;
  logic             issue;
  logic [31:0]      rs1_sel;
  logic [31:0]      rs2_sel;
  logic             unsign_sel;
  logic             rem_sel;
  logic [TAG_W-1:0] rd_sel;

  // A flushed thread is not offered to the arbiter, so it cannot block the other.
  assign elig = req_valid & ~flush;

  eh2_exu_div_rr_arb u_arb (
    .clk    (clk),
    .rst_l  (rst_l),
    .valid  (elig),
    .accept (accept),
    .grant  (grant)
  );

  assign sel        = grant[1];
  assign rs1_sel    = sel ? req_rs1[63:32] : req_rs1[31:0];
  assign rs2_sel    = sel ? req_rs2[63:32] : req_rs2[31:0];
  assign unsign_sel = sel ? req_unsign[1] : req_unsign[0];
  assign rem_sel    = sel ? req_rem[1] : req_rem[0];
  assign rd_sel     = sel ? req_rd[2*TAG_W-1:TAG_W] : req_rd[TAG_W-1:0];

  assign own_flush  = flush[tid_q];

  // Combinational outputs are gated with rst_l so they read 0 the moment reset drops.
  assign req_ready  = (rst_l && (state_q == DIV_IDLE)) ? (grant & ~flush) : '0;
  assign accept     = |(req_ready & req_valid);

`ifdef RV_DIV_RESULT_CACHE_EN
  logic        cache_vld_q;
  logic [31:0] cache_rs1_q;
  logic [31:0] cache_rs2_q;
  logic        cache_uns_q;
  logic        cache_rem_q;
  logic [31:0] cache_res_q;
  // Operands of the op in flight, held so a completed result can fill the cache.
  logic [31:0] op_rs1_q;
  logic [31:0] op_rs2_q;
  logic        op_uns_q;
  logic        rem_q;

  assign cache_hit = cache_vld_q
                   & (cache_rs1_q == rs1_sel)
                   & (cache_rs2_q == rs2_sel)
                   & (cache_uns_q == unsign_sel)
                   & (cache_rem_q == rem_sel);
`else
  assign cache_hit = 1'b0;
`endif

  assign issue = accept & ~cache_hit;

  always_comb begin
    div_dp        = '0;
    div_dp.valid  = issue;
    div_dp.unsign = issue & unsign_sel;
    div_dp.rem    = issue & rem_sel;
  end

  assign div_dividend = issue ? rs1_sel : '0;
  assign div_divisor  = issue ? rs2_sel : '0;

  // Cancel only for the owning thread's flush; it beats a same-cycle finish.
  assign div_cancel = rst_l & (state_q == DIV_RUN) & own_flush;

  assign wb_valid = rst_l & (state_q == DIV_WB) & ~own_flush;
  assign wb_tid   = tid_q;
  assign wb_rd    = rd_q;
  assign wb_data  = data_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= DIV_IDLE;
      tid_q       <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
`ifdef RV_DIV_RESULT_CACHE_EN
      cache_vld_q <= 1'b0;
      cache_rs1_q <= '0;
      cache_rs2_q <= '0;
      cache_uns_q <= 1'b0;
      cache_rem_q <= 1'b0;
      cache_res_q <= '0;
      op_rs1_q    <= '0;
      op_rs2_q    <= '0;
      op_uns_q    <= 1'b0;
      rem_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (accept) begin
            tid_q <= sel;
            rd_q  <= rd_sel;
`ifdef RV_DIV_RESULT_CACHE_EN
            op_rs1_q <= rs1_sel;
            op_rs2_q <= rs2_sel;
            op_uns_q <= unsign_sel;
            rem_q    <= rem_sel;
            if (cache_hit) begin
              data_q  <= cache_res_q;
              state_q <= DIV_WB;
            end else begin
              state_q <= DIV_RUN;
            end
`else
            state_q <= DIV_RUN;
`endif
          end
        end
        DIV_RUN: begin
          if (own_flush) begin
            state_q <= DIV_IDLE;
          end else if (div_finish_dly) begin
            data_q  <= div_out;
            state_q <= DIV_WB;
`ifdef RV_DIV_RESULT_CACHE_EN
            cache_vld_q <= 1'b1;
            cache_rs1_q <= op_rs1_q;
            cache_rs2_q <= op_rs2_q;
            cache_uns_q <= op_uns_q;
            cache_rem_q <= rem_q;
            cache_res_q <= div_out;
`endif
          end
        end
        DIV_WB: begin
          // Data registers are untouched here, so the writeback stays stable while stalled.
          if (own_flush || (wb_valid && wb_ready)) begin
            state_q <= DIV_IDLE;
          end
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eh2_exu_div_sched.sv
// tb/tb_eh2_exu_div_sched.sv - self-checking bench for eh2_exu_div_sched
module tb_eh2_exu_div_sched;
  import eh2_pkg::*;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_rs1 = '0;
  logic [63:0] req_rs2 = '0;
  logic [1:0]  req_unsign = '0;
  logic [1:0]  req_rem = '0;
  logic [9:0]  req_rd = '0;
  logic [1:0]  flush = '0;
  eh2_div_pkt_t div_dp;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_cancel;
  logic        div_finish_dly = 1'b0;
  logic [31:0] div_out = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic        wb_tid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  eh2_exu_div_sched #(.NUM_THREADS(2), .TAG_W(5)) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_rs1        (req_rs1),
    .req_rs2        (req_rs2),
    .req_unsign     (req_unsign),
    .req_rem        (req_rem),
    .req_rd         (req_rd),
    .flush          (flush),
    .div_dp         (div_dp),
    .div_dividend   (div_dividend),
    .div_divisor    (div_divisor),
    .div_cancel     (div_cancel),
    .div_finish_dly (div_finish_dly),
    .div_out        (div_out),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_tid         (wb_tid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RISC-V divide semantics, used both as the divider stand-in and as the reference.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                         input logic uns, input logic rem);
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : a;
    if (uns) return rem ? (a % b) : (a / b);
    return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
  endfunction

  // ---------------- behavioural model ----------------
  // One outstanding op: either waiting on the divider or waiting on writeback.
  bit          m_wait_div = 0;
  bit          m_wait_wb = 0;
  int          m_tid = 0;
  int          m_last = 1;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;
  logic [1:0]  e_ready = '0;
  bit          e_accept = 0;
  int          e_pick = 0;
  bit          e_hit = 0;
`ifdef RV_DIV_RESULT_CACHE_EN
  bit          c_vld = 0;
  logic [31:0] c_rs1, c_rs2, c_res, p_rs1, p_rs2;
  bit          c_uns, c_rem, p_uns, p_rem;
`endif

  always @(negedge clk) begin
    if (!rst_l) begin
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_div_dp", 32'(div_dp), 32'd0);
      check("rst_div_cancel", 32'(div_cancel), 32'd0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_wb_rd", 32'(wb_rd), 32'd0);
      check("rst_wb_tid", 32'(wb_tid), 32'd0);
    end else begin
      logic [1:0] elig;
      elig = req_valid & ~flush;
      e_ready = '0;
      if (!m_wait_div && !m_wait_wb) begin
        if (elig == 2'b11) e_ready = (m_last == 1) ? 2'b01 : 2'b10;
        else e_ready = elig;
      end
      e_accept = (e_ready != 2'b00);
      e_pick = e_ready[1] ? 1 : 0;
      e_hit = 0;
`ifdef RV_DIV_RESULT_CACHE_EN
      e_hit = e_accept && c_vld && req_rs1[e_pick*32 +: 32] == c_rs1 &&
              req_rs2[e_pick*32 +: 32] == c_rs2 && req_unsign[e_pick] == c_uns &&
              req_rem[e_pick] == c_rem;
`endif
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("div_valid", 32'(div_dp.valid), 32'(e_accept && !e_hit));
      if (e_accept && !e_hit) begin
        check("div_dividend", div_dividend, req_rs1[e_pick*32 +: 32]);
        check("div_divisor", div_divisor, req_rs2[e_pick*32 +: 32]);
        check("div_unsign", 32'(div_dp.unsign), 32'(req_unsign[e_pick]));
        check("div_rem", 32'(div_dp.rem), 32'(req_rem[e_pick]));
      end
      check("div_cancel", 32'(div_cancel), 32'(m_wait_div && flush[m_tid]));
      check("wb_valid", 32'(wb_valid), 32'(m_wait_wb && !flush[m_tid]));
      if (m_wait_wb) begin
        check("wb_tid", 32'(wb_tid), 32'(m_tid));
        check("wb_rd", 32'(wb_rd), 32'(m_rd));
        check("wb_data", wb_data, m_data);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_l) begin
      m_wait_div = 0;
      m_wait_wb = 0;
      m_last = 1;
`ifdef RV_DIV_RESULT_CACHE_EN
      c_vld = 0;
`endif
    end else if (!m_wait_div && !m_wait_wb) begin
      if (e_accept) begin
        m_last = e_pick;
        m_tid = e_pick;
        m_rd = req_rd[e_pick*5 +: 5];
`ifdef RV_DIV_RESULT_CACHE_EN
        p_rs1 = req_rs1[e_pick*32 +: 32];
        p_rs2 = req_rs2[e_pick*32 +: 32];
        p_uns = req_unsign[e_pick];
        p_rem = req_rem[e_pick];
        if (e_hit) m_data = c_res;
`endif
        if (e_hit) m_wait_wb = 1;
        else m_wait_div = 1;
      end
    end else if (m_wait_div) begin
      if (flush[m_tid]) m_wait_div = 0;
      else if (div_finish_dly) begin
        m_data = div_out;
        m_wait_div = 0;
        m_wait_wb = 1;
`ifdef RV_DIV_RESULT_CACHE_EN
        c_vld = 1; c_rs1 = p_rs1; c_rs2 = p_rs2; c_uns = p_uns; c_rem = p_rem; c_res = div_out;
`endif
      end
    end else begin
      if (flush[m_tid] || wb_ready) m_wait_wb = 0;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int t, input logic [31:0] a, input logic [31:0] b,
                         input logic uns, input logic rem, input logic [4:0] rd);
    req_valid[t] = 1'b1;
    req_rs1[t*32 +: 32] = a;
    req_rs2[t*32 +: 32] = b;
    req_unsign[t] = uns;
    req_rem[t] = rem;
    req_rd[t*5 +: 5] = rd;
  endtask

  task automatic finish(input logic [31:0] r);
    div_finish_dly = 1'b1;
    div_out = r;
    step();
    div_finish_dly = 1'b0;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    req_valid = '0; flush = '0; wb_ready = 1'b0; div_finish_dly = 1'b0;
    step();
    step();
    rst_l = 1'b1;
  endtask

  task automatic drain_wb();
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with requests pending: nothing may be accepted.
    req_valid = 2'b11;
    @(negedge clk);
    check("lit_rst_ready", 32'(req_ready), 32'd0);
    do_reset();

    // T0 signed 100/7.
    check("lit_ref_100_7", ref_div(32'd100, 32'd7, 1'b0, 1'b0), 32'd14);
    set_req(0, 32'd100, 32'd7, 1'b0, 1'b0, 5'd5);
    @(negedge clk);
    check("lit_s1_issue", 32'(div_dp.valid), 32'd1);
    check("lit_s1_dividend", div_dividend, 32'd100);
    step();
    req_valid = '0;
    @(negedge clk);
    check("lit_s1_one_cycle", 32'(div_dp.valid), 32'd0);
    step();
    step();
    finish(ref_div(32'd100, 32'd7, 1'b0, 1'b0));
    wb_ready = 1'b1;
    @(negedge clk);
    check("lit_s1_wb_valid", 32'(wb_valid), 32'd1);
    check("lit_s1_wb_tid", 32'(wb_tid), 32'd0);
    check("lit_s1_wb_data", wb_data, 32'd14);
    step();
    wb_ready = 1'b0;

    // Both threads request on the first cycle after reset.
    do_reset();
    set_req(0, 32'd81, 32'd9, 1'b1, 1'b0, 5'd1);
    set_req(1, 32'd50, 32'd5, 1'b1, 1'b0, 5'd2);
    @(negedge clk);
    check("lit_s2_first", 32'(req_ready), 32'd1);
    step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("lit_s2_busy", 32'(req_ready), 32'd0);
    step();
    finish(ref_div(32'd81, 32'd9, 1'b1, 1'b0));
    drain_wb();
    @(negedge clk);
    check("lit_s2_t1_next", 32'(req_ready), 32'd2);
    step();
    req_valid = '0;
    finish(ref_div(32'd50, 32'd5, 1'b1, 1'b0));
    wb_ready = 1'b1;
    @(negedge clk);
    check("lit_s2_wb_tid", 32'(wb_tid), 32'd1);
    check("lit_s2_wb_data", wb_data, 32'd10);
    step();
    wb_ready = 1'b0;

    // T1 op cancelled by its own flush; flush of T0 is ignored.
    set_req(1, 32'd77, 32'd0, 1'b0, 1'b1, 5'd7);
    step();
    req_valid = '0;
    flush = 2'b01;
    @(negedge clk);
    check("lit_s3_other_flush", 32'(div_cancel), 32'd0);
    step();
    flush = 2'b10;
    @(negedge clk);
    check("lit_s3_cancel", 32'(div_cancel), 32'd1);
    step();
    flush = 2'b00;
    set_req(0, 32'd200, 32'hFFFF_FFF8, 1'b0, 1'b0, 5'd9);
    @(negedge clk);
    check("lit_s3_cancel_off", 32'(div_cancel), 32'd0);
    check("lit_s3_idle", 32'(req_ready), 32'd1);
    check("lit_s3_no_wb", 32'(wb_valid), 32'd0);

    // Writeback stalled for 5 cycles while both threads request.
    step();
    req_valid = '0;
    step();
    finish(ref_div(32'd200, 32'hFFFF_FFF8, 1'b0, 1'b0));
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("lit_s4_wb_valid", 32'(wb_valid), 32'd1);
      check("lit_s4_wb_rd", 32'(wb_rd), 32'd9);
      check("lit_s4_wb_data", wb_data, 32'hFFFF_FFE7);
      check("lit_s4_ready", 32'(req_ready), 32'd0);
      step();
    end
    req_valid = '0;
    drain_wb();

    // Same remainder op twice, then with rem cleared.
    check("lit_ref_m20_3", ref_div(32'hFFFF_FFEC, 32'd3, 1'b0, 1'b1), 32'hFFFF_FFFE);
    set_req(0, 32'hFFFF_FFEC, 32'd3, 1'b0, 1'b1, 5'd3);
    @(negedge clk);
    check("lit_s5_first_issue", 32'(div_dp.valid), 32'd1);
    step();
    req_valid = '0;
    step();
    finish(ref_div(32'hFFFF_FFEC, 32'd3, 1'b0, 1'b1));
    drain_wb();
    set_req(0, 32'hFFFF_FFEC, 32'd3, 1'b0, 1'b1, 5'd3);
    @(negedge clk);
`ifdef RV_DIV_RESULT_CACHE_EN
    check("lit_s5_hit_no_issue", 32'(div_dp.valid), 32'd0);
    check("lit_s5_hit_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = '0;
    @(negedge clk);
    check("lit_s5_hit_wb", 32'(wb_valid), 32'd1);
    check("lit_s5_hit_data", wb_data, 32'hFFFF_FFFE);
    drain_wb();
`else
    check("lit_s5_repeat_issue", 32'(div_dp.valid), 32'd1);
    step();
    req_valid = '0;
    finish(ref_div(32'hFFFF_FFEC, 32'd3, 1'b0, 1'b1));
    drain_wb();
`endif
    set_req(0, 32'hFFFF_FFEC, 32'd3, 1'b0, 1'b0, 5'd3);
    @(negedge clk);
    check("lit_s5_div_issue", 32'(div_dp.valid), 32'd1);
    step();
    req_valid = '0;
    finish(ref_div(32'hFFFF_FFEC, 32'd3, 1'b0, 1'b0));
    wb_ready = 1'b1;
    @(negedge clk);
    check("lit_s5_div_data", wb_data, 32'hFFFF_FFFA);
    step();
    wb_ready = 1'b0;

    // Reset dropped mid-RUN.
    set_req(0, 32'd9, 32'd2, 1'b1, 1'b0, 5'd4);
    step();
    req_valid = '0;
    #1;
    flush = 2'b01;
    #1;
    check("lit_s6_pre_cancel", 32'(div_cancel), 32'd1);
    rst_l = 1'b0;
    #1;
    check("lit_s6_cancel", 32'(div_cancel), 32'd0);
    check("lit_s6_wb_data", wb_data, 32'd0);
    check("lit_s6_wb_rd", 32'(wb_rd), 32'd0);
    check("lit_s6_dp", 32'(div_dp), 32'd0);
    flush = 2'b00;
    step();
    step();
    rst_l = 1'b1;
    finish(32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("lit_s6_no_wb", 32'(wb_valid), 32'd0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
